// File: rtl/alu_reg_sequencer_pkg.sv
// Shared constants and types for the ALU/register-file sequencer and its datapath.
// Holds ALU operation codes (common with the datapath top), FSM state encoding,
// address/data/counter widths and the packed payload structs used by the sequencer.
package alu_reg_sequencer_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned OPS_W  = 16;
    localparam int unsigned CNT_W  = 4;

    // ALU operation codes shared with the datapath
    localparam logic [OP_W-1:0] ALU_AND = 3'd0;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd1;
    localparam logic [OP_W-1:0] ALU_ADD = 3'd2;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [OP_W-1:0] ALU_NOR = 3'd5;
    localparam logic [OP_W-1:0] ALU_SLT = 3'd6;
    localparam logic [OP_W-1:0] ALU_SLL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WB     = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Register-file / ALU control presented to the datapath
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] w;
    } rf_ctrl_t;

    // Captured ALU result and flags
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              of;
        logic              zf;
    } rsp_t;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Bus bundle between the sequencer, its command source, the register-file/ALU
// datapath and the response consumer.
//   master : environment side (drives commands, ALU results, rsp_ready)
//   slave  : sequencer side (drives cmd_ready, register-file controls, response)
interface alu_reg_sequencer_if;
    import alu_reg_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_a;
    logic [ADDR_W-1:0] cmd_b;
    logic [ADDR_W-1:0] cmd_w;
    logic              cmd_wb;

    logic [ADDR_W-1:0] R_Addr_A;
    logic [ADDR_W-1:0] R_Addr_B;
    logic [ADDR_W-1:0] W_Addr;
    logic [OP_W-1:0]   ALU_OP;
    logic              Write_Reg;

    logic [DATA_W-1:0] alu_f;
    logic              alu_of;
    logic              alu_zf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_of;
    logic              rsp_zf;
    logic [OPS_W-1:0]  ops_done;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_w, cmd_wb,
        input  cmd_ready,
        input  R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
        output alu_f, alu_of, alu_zf,
        input  rsp_valid, rsp_data, rsp_of, rsp_zf, ops_done,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_w, cmd_wb,
        output cmd_ready,
        output R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Write_Reg,
        input  alu_f, alu_of, alu_zf,
        output rsp_valid, rsp_data, rsp_of, rsp_zf, ops_done,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_reg_sequencer.sv
// Sequencer for one register-file read / ALU / optional write-back operation.
// Accepts a command, drives register-file addresses and ALU_OP, waits
// SETTLE_CYCLES for the datapath, captures result and flags, optionally
// pulses Write_Reg for one cycle, then holds the response until accepted.
// Ports:
//   clk   : clock, all state on rising edge
//   Reset : synchronous active-low reset
//   bus   : slave side of alu_reg_sequencer_if (command, datapath, response)
module alu_reg_sequencer
    import alu_reg_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              Reset,
    alu_reg_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_q, wb_d;
    rf_ctrl_t         rf_q, rf_d;
    rsp_t             rsp_q, rsp_d;
    logic             write_reg_q, write_reg_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [OPS_W-1:0] ops_q, ops_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wb_q        <= 1'b0;
            rf_q        <= '0;
            rsp_q       <= '0;
            write_reg_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_q        <= wb_d;
            rf_q        <= rf_d;
            rsp_q       <= rsp_d;
            write_reg_q <= write_reg_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            ops_q       <= ops_d;
        end
    end

    // Next state and next output values; output flags follow the next state
    // so that each registered flag is valid for the whole cycle of its state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_d        = wb_q;
        rf_d        = rf_q;
        rsp_d       = rsp_q;
        ops_d       = ops_q;
        write_reg_d = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready_q gates acceptance so nothing is taken in the
                // first cycle after reset release
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d = ST_SETTLE;
                    rf_d    = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, w: bus.cmd_w};
                    wb_d    = bus.cmd_wb;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    // capture before any write-back can disturb alu_f
                    rsp_d   = '{data: bus.alu_f, of: bus.alu_of, zf: bus.alu_zf};
                    state_d = wb_q ? ST_WB : ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    ops_d   = ops_q + OPS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        write_reg_d = (state_d == ST_WB);
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.R_Addr_A  = rf_q.a;
    assign bus.R_Addr_B  = rf_q.b;
    assign bus.W_Addr    = rf_q.w;
    assign bus.ALU_OP    = rf_q.op;
    assign bus.Write_Reg = write_reg_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_of    = rsp_q.of;
    assign bus.rsp_zf    = rsp_q.zf;
    assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Self-checking bench for alu_reg_sequencer: a register-file/ALU datapath
// model feeds alu_f/flags for the SETTLE_CYCLES=1 instance, a second instance
// with SETTLE_CYCLES=4 is driven with fixed ALU values.
module tb_alu_reg_sequencer;
    import alu_reg_sequencer_pkg::*;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    alu_reg_sequencer_if ifa ();
    alu_reg_sequencer_if ifb ();

    alu_reg_sequencer #(.SETTLE_CYCLES(1)) u_dut_a (.clk(clk), .Reset(Reset), .bus(ifa));
    alu_reg_sequencer #(.SETTLE_CYCLES(4)) u_dut_b (.clk(clk), .Reset(Reset), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    // Behavioural ALU: returns {overflow, result}
    function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        o;
        r = '0;
        o = 1'b0;
        case (op)
            ALU_AND: r = x & y;
            ALU_OR:  r = x | y;
            ALU_ADD: begin r = x + y; o = (x[31] == y[31]) && (r[31] != x[31]); end
            ALU_SUB: begin r = x - y; o = (x[31] != y[31]) && (r[31] != x[31]); end
            ALU_XOR: r = x ^ y;
            ALU_NOR: r = ~(x | y);
            ALU_SLT: r = {31'd0, ($signed(x) < $signed(y))};
            default: r = x << y[4:0];
        endcase
        return {o, r};
    endfunction

    // Datapath environment for instance A: register file plus ALU
    logic [31:0] regs [32];
    logic [31:0] ref_regs [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic [32:0] dp_res;

    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (ifa.Write_Reg === 1'b1) regs[ifa.W_Addr] <= ifa.alu_f;
    end

    assign dp_res     = alu_ref(ifa.ALU_OP, regs[ifa.R_Addr_A], regs[ifa.R_Addr_B]);
    assign ifa.alu_f  = dp_res[31:0];
    assign ifa.alu_of = dp_res[32];
    assign ifa.alu_zf = (dp_res[31:0] == 32'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input logic [4:0] addr, input logic [31:0] data);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        tick();
        pl_en = 1'b0;
        ref_regs[addr] = data;
    endtask

    // Drives one command on instance A and reports what it observed.
    // lat/wr_lat are edges after the accepting edge; lat=-1 on timeout.
    task automatic do_cmd(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] w, input logic wb, input int hold, input bit noise,
                          output int lat, output int wr_cnt, output int wr_lat, output logic [4:0] wr_addr,
                          output logic [31:0] data, output logic of, output logic zf,
                          output bit stable_ok, output bit held_ok);
        int cyc;
        lat = -1; wr_cnt = 0; wr_lat = -1; wr_addr = '0; data = '0; of = 1'b0; zf = 1'b0;
        stable_ok = 1'b1; held_ok = 1'b1;
        ifa.cmd_op = op; ifa.cmd_a = a; ifa.cmd_b = b; ifa.cmd_w = w; ifa.cmd_wb = wb;
        ifa.cmd_valid = 1'b1;
        ifa.rsp_ready = (hold == 0);
        tick();
        ifa.cmd_valid = noise;
        ifa.cmd_op = ~op; ifa.cmd_a = ~a; ifa.cmd_b = ~b; ifa.cmd_w = ~w; ifa.cmd_wb = ~wb;
        cyc = 0;
        while (lat < 0 && cyc <= 40) begin
            if (ifa.R_Addr_A !== a || ifa.R_Addr_B !== b || ifa.W_Addr !== w || ifa.ALU_OP !== op) held_ok = 1'b0;
            if (ifa.cmd_ready !== 1'b0) stable_ok = 1'b0;
            if (ifa.Write_Reg === 1'b1) begin wr_cnt++; wr_lat = cyc; wr_addr = ifa.W_Addr; end
            if (ifa.rsp_valid === 1'b1) lat = cyc;
            else begin tick(); cyc++; end
        end
        if (lat < 0) begin
            ifa.cmd_valid = 1'b0; ifa.rsp_ready = 1'b1;
            return;
        end
        data = ifa.rsp_data; of = ifa.rsp_of; zf = ifa.rsp_zf;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (ifa.rsp_valid !== 1'b1 || ifa.rsp_data !== data || ifa.rsp_of !== of || ifa.rsp_zf !== zf ||
                ifa.cmd_ready !== 1'b0 || ifa.Write_Reg !== 1'b0) stable_ok = 1'b0;
            if (ifa.R_Addr_A !== a || ifa.R_Addr_B !== b || ifa.W_Addr !== w || ifa.ALU_OP !== op) held_ok = 1'b0;
        end
        ifa.rsp_ready = 1'b1;
        tick();
        ifa.rsp_ready = 1'b0;
        ifa.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        ifa.cmd_valid = 1'b1; ifb.cmd_valid = 1'b1;
        tick(); tick();
        checks++;
        if ({ifa.R_Addr_A, ifa.R_Addr_B, ifa.W_Addr, ifa.ALU_OP, ifa.Write_Reg, ifa.rsp_valid} !== '0) begin
            errors++; $display("FAIL reset_ctrl_a: got %h want 0", {ifa.R_Addr_A, ifa.R_Addr_B, ifa.W_Addr, ifa.ALU_OP, ifa.Write_Reg, ifa.rsp_valid});
        end
        checks++;
        if ({ifa.rsp_data, ifa.rsp_of, ifa.rsp_zf, ifa.ops_done} !== '0) begin
            errors++; $display("FAIL reset_rsp_a: got %h want 0", {ifa.rsp_data, ifa.rsp_of, ifa.rsp_zf, ifa.ops_done});
        end
        checks++;
        if (ifa.cmd_ready !== 1'b0 || ifb.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready: got a=%b b=%b want 0", ifa.cmd_ready, ifb.cmd_ready);
        end
        checks++;
        if ({ifb.R_Addr_A, ifb.W_Addr, ifb.ALU_OP, ifb.Write_Reg, ifb.rsp_valid, ifb.rsp_data, ifb.ops_done} !== '0) begin
            errors++; $display("FAIL reset_all_b: got %h want 0", {ifb.R_Addr_A, ifb.W_Addr, ifb.ALU_OP, ifb.Write_Reg, ifb.rsp_valid, ifb.rsp_data, ifb.ops_done});
        end
        ifa.cmd_valid = 1'b0; ifb.cmd_valid = 1'b0;
        Reset = 1'b1;
        tick();
        checks++;
        if (ifa.cmd_ready !== 1'b1 || ifb.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL release_cmd_ready: got a=%b b=%b want 1", ifa.cmd_ready, ifb.cmd_ready);
        end
        exp_ops = 0;
    endtask

    task automatic test_writeback();
        int lat, wr_cnt, wr_lat; logic [4:0] wr_addr; logic [31:0] d; logic o, z; bit st, hd;
        set_reg(5'd0, 32'd5);
        set_reg(5'd1, 32'd7);
        do_cmd(ALU_ADD, 5'd0, 5'd1, 5'd3, 1'b1, 0, 1'b0, lat, wr_cnt, wr_lat, wr_addr, d, o, z, st, hd);
        exp_ops++;
        checks++;
        if (lat != 2) begin errors++; $display("FAIL wb_latency: got %0d want 2", lat); end
        checks++;
        if (wr_cnt != 1 || wr_lat != 1 || wr_addr !== 5'd3) begin
            errors++; $display("FAIL wb_pulse: got cnt=%0d at=%0d addr=%0d want cnt=1 at=1 addr=3", wr_cnt, wr_lat, wr_addr);
        end
        checks++;
        if (d !== 32'h0000000C) begin errors++; $display("FAIL wb_data: got %h want 0000000c", d); end
        checks++;
        if (ifa.rsp_valid !== 1'b0 || ifa.cmd_ready !== 1'b1 || ifa.ops_done !== 16'(exp_ops)) begin
            errors++; $display("FAIL wb_done: got valid=%b ready=%b ops=%0d want 0 1 %0d", ifa.rsp_valid, ifa.cmd_ready, ifa.ops_done, exp_ops);
        end
        checks++;
        if (regs[3] !== 32'h0000000C) begin errors++; $display("FAIL wb_regfile: got %h want 0000000c", regs[3]); end
        ref_regs[3] = 32'h0000000C;
    endtask

    task automatic test_same_reg();
        int lat, wr_cnt, wr_lat; logic [4:0] wr_addr; logic [31:0] d; logic o, z; bit st, hd;
        set_reg(5'd3, 32'd1);
        set_reg(5'd4, 32'd4);
        do_cmd(ALU_ADD, 5'd3, 5'd4, 5'd3, 1'b1, 3, 1'b0, lat, wr_cnt, wr_lat, wr_addr, d, o, z, st, hd);
        exp_ops++;
        checks++;
        if (d !== 32'h5 || st !== 1'b1) begin errors++; $display("FAIL same_reg_data: got %h stable=%b want 5 1", d, st); end
        checks++;
        if (regs[3] !== 32'h5 || ifa.rsp_data !== 32'h5) begin
            errors++; $display("FAIL same_reg_after: got reg=%h rsp=%h want 5 5", regs[3], ifa.rsp_data);
        end
        ref_regs[3] = 32'h5;
    endtask

    task automatic test_backpressure();
        int lat, wr_cnt, wr_lat; logic [4:0] wr_addr; logic [31:0] d; logic o, z; bit st, hd;
        logic [32:0] e;
        e = alu_ref(ALU_XOR, ref_regs[9], ref_regs[17]);
        do_cmd(ALU_XOR, 5'd9, 5'd17, 5'd20, 1'b0, 5, 1'b1, lat, wr_cnt, wr_lat, wr_addr, d, o, z, st, hd);
        exp_ops++;
        checks++;
        if (lat != 1 || wr_cnt != 0) begin errors++; $display("FAIL bp_latency: got lat=%0d wr=%0d want 1 0", lat, wr_cnt); end
        checks++;
        if (st !== 1'b1 || hd !== 1'b1) begin errors++; $display("FAIL bp_stable: got stable=%b held=%b want 1 1", st, hd); end
        checks++;
        if (d !== e[31:0]) begin errors++; $display("FAIL bp_data: got %h want %h", d, e[31:0]); end
        checks++;
        if (ifa.rsp_valid !== 1'b0 || ifa.cmd_ready !== 1'b1 || ifa.ops_done !== 16'(exp_ops)) begin
            errors++; $display("FAIL bp_done: got valid=%b ready=%b ops=%0d want 0 1 %0d", ifa.rsp_valid, ifa.cmd_ready, ifa.ops_done, exp_ops);
        end
        tick(); tick();
        checks++;
        if (ifa.R_Addr_A !== 5'd9 || ifa.R_Addr_B !== 5'd17 || ifa.W_Addr !== 5'd20 || ifa.ALU_OP !== ALU_XOR) begin
            errors++; $display("FAIL idle_hold: got a=%0d b=%0d w=%0d op=%0d want 9 17 20 4", ifa.R_Addr_A, ifa.R_Addr_B, ifa.W_Addr, ifa.ALU_OP);
        end
    endtask

    task automatic test_random();
        int lat, wr_cnt, wr_lat; logic [4:0] wr_addr; logic [31:0] d; logic o, z; bit st, hd;
        logic [2:0] op; logic [4:0] a, b, w; logic wb; int hold; bit noise; logic [32:0] e;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7)); a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31)); w = 5'($urandom_range(0, 31));
            wb = 1'($urandom_range(0, 1)); hold = $urandom_range(0, 3); noise = 1'($urandom_range(0, 1));
            if (n % 8 == 0) b = a;
            e = alu_ref(op, ref_regs[a], ref_regs[b]);
            do_cmd(op, a, b, w, wb, hold, noise, lat, wr_cnt, wr_lat, wr_addr, d, o, z, st, hd);
            exp_ops = (exp_ops + 1) & 32'hFFFF;
            if (wb) ref_regs[w] = e[31:0];
            checks++;
            if (lat != 1 + int'(wb) || wr_cnt != int'(wb)) begin
                errors++; $display("FAIL rnd_timing[%0d]: got lat=%0d wr=%0d want %0d %0d", n, lat, wr_cnt, 1 + int'(wb), int'(wb));
            end
            checks++;
            if (wb && (wr_addr !== w || wr_lat != 1)) begin
                errors++; $display("FAIL rnd_wr_addr[%0d]: got addr=%0d at=%0d want %0d 1", n, wr_addr, wr_lat, w);
            end
            checks++;
            if ({d, o, z} !== {e[31:0], e[32], (e[31:0] == 32'd0)}) begin
                errors++; $display("FAIL rnd_result[%0d]: got %h of=%b zf=%b want %h of=%b zf=%b", n, d, o, z, e[31:0], e[32], (e[31:0] == 32'd0));
            end
            checks++;
            if (st !== 1'b1 || hd !== 1'b1) begin errors++; $display("FAIL rnd_stable[%0d]: got stable=%b held=%b want 1 1", n, st, hd); end
            checks++;
            if (ifa.rsp_valid !== 1'b0 || ifa.cmd_ready !== 1'b1 || ifa.ops_done !== 16'(exp_ops)) begin
                errors++; $display("FAIL rnd_done[%0d]: got valid=%b ready=%b ops=%0d want 0 1 %0d", n, ifa.rsp_valid, ifa.cmd_ready, ifa.ops_done, exp_ops);
            end
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (regs[i] !== ref_regs[i]) begin errors++; $display("FAIL regfile[%0d]: got %h want %h", i, regs[i], ref_regs[i]); end
        end
    endtask

    task automatic test_settle4();
        int cyc; int wr_cnt;
        ifb.alu_f = 32'd0; ifb.alu_of = 1'b1; ifb.alu_zf = 1'b1; ifb.rsp_ready = 1'b0;
        ifb.cmd_op = ALU_SUB; ifb.cmd_a = 5'd7; ifb.cmd_b = 5'd7; ifb.cmd_w = 5'd9; ifb.cmd_wb = 1'b0;
        ifb.cmd_valid = 1'b1;
        tick();
        ifb.cmd_valid = 1'b0;
        cyc = 0;
        while (ifb.rsp_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL s4_latency: got %0d want 4", cyc); end
        ifb.alu_f = 32'hDEADBEEF; ifb.alu_of = 1'b0; ifb.alu_zf = 1'b0;
        tick();
        checks++;
        if ({ifb.rsp_valid, ifb.rsp_data, ifb.rsp_of, ifb.rsp_zf} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL s4_flags: got v=%b d=%h of=%b zf=%b want 1 0 1 1", ifb.rsp_valid, ifb.rsp_data, ifb.rsp_of, ifb.rsp_zf);
        end
        ifb.rsp_ready = 1'b1;
        tick();
        checks++;
        if (ifb.rsp_valid !== 1'b0 || ifb.ops_done !== 16'd1) begin
            errors++; $display("FAIL s4_done: got valid=%b ops=%0d want 0 1", ifb.rsp_valid, ifb.ops_done);
        end
        ifb.alu_f = 32'h12345678;
        ifb.cmd_wb = 1'b1; ifb.cmd_valid = 1'b1;
        tick();
        ifb.cmd_valid = 1'b0;
        cyc = 0; wr_cnt = 0;
        while (ifb.rsp_valid !== 1'b1 && cyc < 40) begin
            if (ifb.Write_Reg === 1'b1) wr_cnt++;
            tick(); cyc++;
        end
        checks++;
        if (cyc != 5 || wr_cnt != 1 || ifb.rsp_data !== 32'h12345678) begin
            errors++; $display("FAIL s4_wb: got lat=%0d wr=%0d d=%h want 5 1 12345678", cyc, wr_cnt, ifb.rsp_data);
        end
        tick();
        ifb.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_wb();
        int cyc; bit quiet;
        ifa.cmd_op = ALU_OR; ifa.cmd_a = 5'd2; ifa.cmd_b = 5'd5; ifa.cmd_w = 5'd6; ifa.cmd_wb = 1'b1;
        ifa.cmd_valid = 1'b1; ifa.rsp_ready = 1'b1;
        tick();
        ifa.cmd_valid = 1'b0;
        cyc = 0;
        while (ifa.Write_Reg !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL rwb_reach: got %0d want 1", cyc); end
        Reset = 1'b0;
        tick();
        checks++;
        if ({ifa.Write_Reg, ifa.rsp_valid, ifa.cmd_ready, ifa.ops_done, ifb.ops_done} !== '0) begin
            errors++; $display("FAIL rwb_reset: got wr=%b v=%b rdy=%b ops=%0d/%0d want all 0", ifa.Write_Reg, ifa.rsp_valid, ifa.cmd_ready, ifa.ops_done, ifb.ops_done);
        end
        Reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifa.Write_Reg !== 1'b0 || ifa.rsp_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1 || ifa.ops_done !== 16'd0 || ifa.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rwb_after: got quiet=%b ops=%0d rdy=%b want 1 0 1", quiet, ifa.ops_done, ifa.cmd_ready);
        end
        ifa.rsp_ready = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        ifa.cmd_valid = 1'b0; ifa.cmd_op = '0; ifa.cmd_a = '0; ifa.cmd_b = '0; ifa.cmd_w = '0; ifa.cmd_wb = 1'b0;
        ifa.rsp_ready = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = '0; ifb.cmd_a = '0; ifb.cmd_b = '0; ifb.cmd_w = '0; ifb.cmd_wb = 1'b0;
        ifb.rsp_ready = 1'b0; ifb.alu_f = '0; ifb.alu_of = 1'b0; ifb.alu_zf = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) set_reg(5'(i), $urandom);
        test_reset();
        test_writeback();
        test_same_reg();
        test_backpressure();
        test_random();
        test_settle4();
        test_reset_in_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
